// File: rtl/convert_pkg.sv
// convert_pkg: shared constants, FSM encoding and byte selection for the 32-to-8-bit feeder.
// Revision 1.0
`default_nettype none

package convert_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  function automatic logic [BYTE_W-1:0] select_byte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        idx,
    input logic              lsb_first
  );
    logic [1:0] pos;
    pos = lsb_first ? idx : (2'd3 - idx);
    return word[BYTE_W*pos +: BYTE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO; full is registered so it can drive a ready output directly.
// Revision 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & (level_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d = (level_d == FULL_LEVEL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: only entries below level are ever read.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/word_to_uart_feeder.sv
// word_to_uart_feeder: buffers 32-bit words and feeds them bytewise to UART_rs232_tx, paced by TxDone.
// Revision 1.0
`default_nettype none

module word_to_uart_feeder
  import convert_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int LSB_FIRST      = 1,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [31:0]                   InData,
  input  logic                          InValid,
  output logic                          InReady,
  output logic [7:0]                    TxData,
  output logic                          TxEn,
  input  logic                          TxDone,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic             LSB_SEL  = (LSB_FIRST != 0);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              err_q, err_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic              done_rise_q, done_rise_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_dout;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (InValid & InReady),
    .din   (InData),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Level)
  );

  always_comb begin
    // TxDone lives in the Tick domain: two sync stages, then a registered rising edge.
    sync1_d     = TxDone;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    done_rise_d = sync2_q & ~sync3_q;

    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_dout;
          byte_idx_d = 2'd0;
          tx_data_d  = select_byte(fifo_dout, 2'd0, LSB_SEL);
          state_d    = START;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (done_rise_q) begin
          if (byte_idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            gap_cnt_d  = '0;
            state_d    = GAP;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          tx_data_d = select_byte(word_q, byte_idx_q, LSB_SEL);
          state_d   = START;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_idx_q  <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      done_rise_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      done_rise_q <= done_rise_d;
    end
  end

  assign InReady = ~fifo_full;
  assign TxData  = tx_data_q;
  assign TxEn    = (state_q == START);
  assign Busy    = (state_q != IDLE) | ~fifo_empty;
  assign Err     = err_q;

endmodule

`default_nettype wire
